load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator-side memory port between the RV32 core and the single-port data RAM.
- Accepts one load or store request at a time from the core pipeline, using a valid/ready handshake.
- Drives the RAM's byte-addressed word interface. Sub-word stores use read-modify-write; loads are byte/halfword extracted and sign- or zero-extended.
- Returns one response per request, flagging misaligned, out-of-range and illegal-size accesses without touching the RAM.

Parameters:
- RAM_ADDR_WIDTH, 16: word-index bits of the RAM. The valid byte range is 0 to 2^(RAM_ADDR_WIDTH+2)-1.
- XLEN, 32: data and address width. Fixed at 32; parameterised for readability only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit accepts a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access fault (misaligned, out of range, or illegal funct3).
- ram_addr  out  32  byte address to the RAM.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM read word, registered in the RAM. Valid the cycle after a read-addressed cycle; not updated on write cycles.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0. State=IDLE.
- Reset is asynchronous. Asserting rst_n mid-operation forces IDLE and ram_we=0 immediately; no partial write may ever be issued.
- Handshake: a request is accepted when req_valid && req_ready. Address, data, funct3 and store flag are captured into registers.
- resp_valid stays high, with resp_rdata and resp_err stable, until resp_ready. The transfer completes on that cycle and the state returns to IDLE.
- Requests are never accepted in the same cycle a response completes.
- Error check at accept:
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - addr[31:RAM_ADDR_WIDTH+2] != 0.
  - On any error: IDLE -> RESP with resp_err=1, rdata=0, no RAM cycle.
- States:
  - IDLE: waiting for a request.
  - RD: ram_addr = {addr[31:2], 2'b00}, ram_we=0.
  - RD_WAIT: sample ram_rdata.
    - Load: latch the extended result, go to RESP.
    - Sub-word store: merge the new lanes into the latched word, go to WR.
  - WR: ram_we=1 for exactly one cycle with the merged word (or req_wdata for SW), at the word-aligned ram_addr.
  - RESP: response held until resp_ready.
- Transitions:
  - Load: IDLE -> RD -> RD_WAIT -> RESP.
  - SW: IDLE -> WR -> RESP.
  - SB/SH: IDLE -> RD -> RD_WAIT -> WR -> RESP.
- Latency, in cycles from the accept edge to resp_valid: load 3, SW 2, SB/SH 4, error 1.
- Lane rules (little-endian):
  - Byte n occupies bits [8n+7:8n].
  - Halfword at addr[1]=h occupies bits [16h+15:16h].
  - B/H loads sign-extend from the top bit of the extracted lane; BU/HU zero-extend.
- ram_addr is held stable outside IDLE. In IDLE, ram_we=0 and ram_addr holds its last value.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RESP.
- One combinational sub-module, lsu_lane_align:
  - Inputs: word, offset[1:0], funct3, store data.
  - Outputs: the extended load value and the merged store word.
  - This is unit-testable in isolation.
- The FSM, request registers and error check stay in load_store_unit.

Test Plan:
1. Word 0x100 preloaded with 0x8899AABB; LW 0x100 -> resp_rdata=0x8899AABB, resp_err=0, resp_valid 3 cycles after accept, ram_we never high.
2. Same word, one test per access:
   - LB 0x103 -> 0xFFFFFF88.
   - LBU 0x103 -> 0x00000088.
   - LH 0x102 -> 0xFFFF8899.
   - LHU 0x100 -> 0x0000AABB.
3. SB 0x101 with wdata 0x12345677 -> exactly one ram_we cycle with ram_wdata=0x889977BB at ram_addr 0x100; resp 4 cycles after accept; a following LW 0x100 returns 0x889977BB.
4. Error cases: SH 0x101, LW 0x00040000 (RAM_ADDR_WIDTH=16), and load funct3=011 -> each gives resp_err=1 and rdata=0 one cycle after accept; ram_we never asserted; memory unchanged.
5. Hold resp_ready=0 for 5 cycles after an LW -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout; the next request is accepted only in the cycle after the resp handshake.
6. Assert rst_n=0 while in RD_WAIT of an SB -> ram_we stays 0, outputs return to reset values immediately, target word unchanged; after release, an LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request checks for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_e;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    if (store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] repl;
  logic [3:0]      mask;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  // Replicate the store lane across the word, then pick lanes by byte mask.
  always_comb begin
    case (funct3)
      F3_B: begin
        repl = {4{store_data[7:0]}};
        mask = 4'b0001 << offset;
      end
      F3_H: begin
        repl = {2{store_data[15:0]}};
        mask = 4'b0011 << {offset[1], 1'b0};
      end
      default: begin
        repl = store_data;
        mask = 4'b1111;
      end
    endcase
    store_word = word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) store_word[8*i +: 8] = repl[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store port to a registered-read data RAM; sub-word stores use RMW.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] ram_addr,
  output logic            ram_we,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata
);

  state_e          state_q, state_d;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] sdata_q;
  logic [XLEN-1:0] ram_addr_q;
  logic [XLEN-1:0] ram_wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            req_fire;
  logic            resp_fire;
  logic            req_err;
  logic            req_sw;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  lsu_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .word      (ram_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .store_data(sdata_q),
    .load_data (load_data),
    .store_word(store_word)
  );

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    ram_we     = (state_q == S_WR);
    req_fire   = req_valid && req_ready;
    resp_fire  = resp_valid && resp_ready;
    req_sw     = req_store && (req_funct3 == F3_W);
    req_err    = !f3_legal(req_store, req_funct3) ||
                 misaligned(req_funct3, req_addr[1:0]) ||
                 (req_addr[XLEN-1:RAM_ADDR_WIDTH+2] != '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)     state_d = S_RESP;
          else if (req_sw) state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = store_q ? S_WR : S_RESP;
      S_WR:      state_d = S_RESP;
      S_RESP:    if (resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      f3_q        <= F3_W;
      off_q       <= 2'b00;
      sdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        sdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
        // Faulting requests never touch the RAM, so its address is left alone.
        if (!req_err) begin
          ram_addr_q <= {req_addr[XLEN-1:2], 2'b00};
          if (req_sw) ram_wdata_q <= req_wdata;
        end
      end else if (state_q == S_RD_WAIT) begin
        if (store_q) ram_wdata_q <= store_word;
        else         rdata_q     <= load_data;
      end else if (resp_fire) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
